vline_filter3: RTL

//  Parametrised vertical 3-tap filter on a pixel stream; generalises the fixed 1-2-1 YCbCr

---
 rtl/vline_filter3.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vline_filter3.sv
// vline_filter3 - vertical 3-tap filter on a packed pixel stream.
//
// Two line delays of LINE_LEN words each provide the top tap (2 lines back) and
// the mid tap (1 line back). iDATA is the bottom tap. The output is the filtered
// mid row. Per channel, the selectable modes are:
//   0 bypass (mid), 1 blur (top+2*mid+bot+2)>>2, 2 max(top,mid,bot),
//   3 edge min(2*|top-bot|, all-ones).
// The mode is latched only on a start-of-frame pixel, so it stays coherent over a frame.
//
// Optional feature: define VFILT_EDGE_REPLICATE_EN to replicate the current line
// into missing taps on the first two lines of a frame (line 0: top=mid=bot,
// line 1: top=mid). When the macro is undefined, the stored taps are used as-is.
//
// Ports:
//   iCLK    pixel clock
//   iRESET  synchronous active-high reset
//   iDVAL   input pixel valid; advances delay lines, counters and pipeline
//   iSOF    start of frame, qualified by iDVAL (marks pixel 0 of line 0)
//   iMODE   filter mode, sampled on iDVAL & iSOF
//   iDATA   input pixel, channel c at [c*DATA_W +: DATA_W]
//   oDVAL   output valid, iDVAL delayed by 2 clocks
//   oDATA   filtered pixel, held while oDVAL is low
//   oMODE   mode currently applied
module vline_filter3 #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int LINE_LEN = 640
) (
    input  logic                         iCLK,
    input  logic                         iRESET,
    input  logic                         iDVAL,
    input  logic                         iSOF,
    input  logic [1:0]                   iMODE,
    input  logic [CHANNELS*DATA_W-1:0]   iDATA,
    output logic                         oDVAL,
    output logic [CHANNELS*DATA_W-1:0]   oDATA,
    output logic [1:0]                   oMODE
);

    localparam int WORD_W = CHANNELS * DATA_W;
    localparam int PTR_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [PTR_W-1:0] LAST_PIX = PTR_W'(LINE_LEN - 1);

    logic [WORD_W-1:0] line1_mem [LINE_LEN];
    logic [WORD_W-1:0] line2_mem [LINE_LEN];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  pix_cnt;
    logic [1:0]        line_cnt;
    logic [1:0]        mode_q;

    logic              sof_px;
    logic [1:0]        cur_mode;
    logic [WORD_W-1:0] tap_top, tap_mid;
    logic [WORD_W-1:0] sel_top, sel_mid, sel_bot;

    logic              s1_vld;
    logic [1:0]        s1_mode;
    logic [WORD_W-1:0] s1_top, s1_mid, s1_bot;
    logic [WORD_W-1:0] filt_data;

    assign sof_px   = iDVAL & iSOF;
    assign cur_mode = sof_px ? iMODE : mode_q;
    assign oMODE    = mode_q;

    // Circular line delays. The pointer is independent of the pixel counter,
    // so an SOF resync never disturbs the exact one-line/two-line delay.
    assign tap_mid = line1_mem[wr_ptr];
    assign tap_top = line2_mem[wr_ptr];

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            line1_mem[wr_ptr] <= iDATA;
            line2_mem[wr_ptr] <= line1_mem[wr_ptr];
        end
    end

    // pix_cnt holds the index of the next pixel; line_cnt saturates at 2 because
    // only "first line", "second line" and "later" matter for the taps.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            wr_ptr   <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            mode_q   <= '0;
        end else if (iDVAL) begin
            wr_ptr <= (wr_ptr == LAST_PIX) ? '0 : wr_ptr + 1'b1;
            if (iSOF) begin
                pix_cnt  <= PTR_W'(1);
                line_cnt <= '0;
                mode_q   <= iMODE;
            end else if (pix_cnt == LAST_PIX) begin
                pix_cnt <= '0;
                if (line_cnt != 2'd2)
                    line_cnt <= line_cnt + 2'd1;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

`ifdef VFILT_EDGE_REPLICATE_EN
    logic [1:0] cur_line;
    assign cur_line = sof_px ? 2'd0 : line_cnt;

    always_comb begin
        sel_top = tap_top;
        sel_mid = tap_mid;
        sel_bot = iDATA;
        if (cur_line == 2'd0) begin
            sel_top = iDATA;
            sel_mid = iDATA;
        end else if (cur_line == 2'd1) begin
            sel_top = tap_mid;
        end
    end
`else
    assign sel_top = tap_top;
    assign sel_mid = tap_mid;
    assign sel_bot = iDATA;
`endif

    // Stage 1: tap capture. Mode travels with the pixel so the SOF pixel
    // already uses the newly sampled mode.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= iDVAL;
        end
        if (iDVAL) begin
            s1_top  <= sel_top;
            s1_mid  <= sel_mid;
            s1_bot  <= sel_bot;
            s1_mode <= cur_mode;
        end
    end

    function automatic logic [DATA_W-1:0] filt(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] t,
        input logic [DATA_W-1:0] m,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W+1:0] sum;
        logic [DATA_W-1:0] diff;
        logic [DATA_W-1:0] mx;
        logic [DATA_W:0]   dbl;
        sum  = {2'b00, t} + {1'b0, m, 1'b0} + {2'b00, b} + (DATA_W+2)'(2);
        diff = (t > b) ? (t - b) : (b - t);
        dbl  = {diff, 1'b0};
        mx   = (t > m) ? t : m;
        mx   = (b > mx) ? b : mx;
        case (mode)
            2'd0:    filt = m;
            2'd1:    filt = DATA_W'(sum >> 2);
            2'd2:    filt = mx;
            default: filt = dbl[DATA_W] ? {DATA_W{1'b1}} : dbl[DATA_W-1:0];
        endcase
    endfunction

    always_comb begin
        filt_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            filt_data[c*DATA_W +: DATA_W] = filt(s1_mode,
                                                 s1_top[c*DATA_W +: DATA_W],
                                                 s1_mid[c*DATA_W +: DATA_W],
                                                 s1_bot[c*DATA_W +: DATA_W]);
        end
    end

    // Stage 2: arithmetic result register.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oDVAL <= 1'b0;
            oDATA <= '0;
        end else begin
            oDVAL <= s1_vld;
            if (s1_vld)
                oDATA <= filt_data;
        end
    end

endmodule
